// File: rtl/tvm_vpi_ram_read_dma_pkg.sv
// Shared constants for the VPI RAM read DMA: FSM encodings and flag positions.
package tvm_vpi_ram_read_dma_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [31:0] SIZE_ZERO = 32'd0;
    localparam logic [31:0] SIZE_ONE  = 32'd1;

    // The last flag rides one bit above the data word inside the FIFO entry.
    function automatic int unsigned last_flag_pos(input int unsigned data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/tvm_sync_fifo.sv
// Small synchronous FIFO with registered full/empty flags.
// Pushes while full and pops while empty are ignored, so a simultaneous
// push and pop on a full FIFO only pops.
module tvm_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !r_full;
    assign w_pop   = i_pop && !r_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

    // Next occupancy; unchanged on a simultaneous push and pop.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

endmodule

// File: rtl/tvm_vpi_ram_read_dma.sv
// Read DMA in front of the VPI RAM read port: one request per command,
// words dequeued into a small FIFO and streamed out with a last marker.
//
// state  | meaning
// IDLE   | accepting a command
// REQ    | one-cycle read request to the RAM
// STREAM | dequeuing RAM words into the FIFO
// DRAIN  | all words fetched, waiting for the last word to leave
// DONE   | one-cycle done pulse
module tvm_vpi_ram_read_dma
    import tvm_vpi_ram_read_dma_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [31:0]           cmd_addr,
    input  logic [31:0]           cmd_size,
    output logic                  ram_read_req,
    output logic [31:0]           ram_read_addr,
    output logic [31:0]           ram_read_size,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    input  logic                  ram_read_valid,
    output logic                  ram_read_dequeue,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned LAST_POS = last_flag_pos(DATA_WIDTH);

    logic [2:0]          r_state;
    logic                r_alive;
    logic [31:0]         r_addr;
    logic [31:0]         r_size;
    logic [31:0]         r_rd_left;
    logic                w_full;
    logic                w_empty;
    logic                w_deq;
    logic                w_pop;
    logic                w_accept;
    logic [DATA_WIDTH:0] w_push_word;
    logic [DATA_WIDTH:0] w_head;

    // r_alive keeps cmd_ready low while in reset and until the first edge after it.
    assign cmd_ready   = r_alive && (r_state == ST_IDLE);
    assign w_accept    = cmd_ready && cmd_valid;
    assign w_deq       = (r_state == ST_STREAM) && ram_read_valid && !w_full
                         && (r_rd_left != SIZE_ZERO);
    assign w_push_word = {(r_rd_left == SIZE_ONE), ram_read_data};
    assign w_pop       = !w_empty && out_ready;

    assign ram_read_req     = (r_state == ST_REQ);
    assign ram_read_addr    = r_addr;
    assign ram_read_size    = r_size;
    assign ram_read_dequeue = w_deq;
    assign out_valid        = !w_empty;
    // Stale FIFO storage is masked so the stream reads zero when empty.
    assign out_data         = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
    assign out_last         = !w_empty && w_head[LAST_POS];
    assign busy             = (r_state != ST_IDLE);
    assign done             = (r_state == ST_DONE);

    tvm_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .i_push      (w_deq),
        .i_push_data (w_push_word),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Command sequencing and remaining-word counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_alive   <= 1'b0;
            r_addr    <= '0;
            r_size    <= '0;
            r_rd_left <= '0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr    <= cmd_addr;
                        r_size    <= cmd_size;
                        r_rd_left <= cmd_size;
                        r_state   <= (cmd_size == SIZE_ZERO) ? ST_DONE : ST_REQ;
                    end
                end
                ST_REQ: begin
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_deq) begin
                        r_rd_left <= r_rd_left - 32'd1;
                        if (r_rd_left == SIZE_ONE) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && w_head[LAST_POS]) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tvm_vpi_ram_read_dma.sv
// Bench for the VPI RAM read DMA: a RAM queue model driving the read port,
// a behavioural model of the engine compared every cycle, a stream
// scoreboard, and directed plus randomized command sequences.
module tb_tvm_vpi_ram_read_dma;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [31:0]   cmd_addr = '0;
    logic [31:0]   cmd_size = '0;
    logic          ram_read_req;
    logic [31:0]   ram_read_addr;
    logic [31:0]   ram_read_size;
    logic [DW-1:0] ram_read_data = '0;
    logic          ram_read_valid = 1'b0;
    logic          ram_read_dequeue;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    tvm_vpi_ram_read_dma #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size),
        .ram_read_req(ram_read_req), .ram_read_addr(ram_read_addr),
        .ram_read_size(ram_read_size), .ram_read_data(ram_read_data),
        .ram_read_valid(ram_read_valid), .ram_read_dequeue(ram_read_dequeue),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // ---------------- RAM model: a word queue with a valid pattern ----------
    logic [DW-1:0] ram_q[$];
    int            vmode  = 0;   // 0 always valid, 1 random, 2 sparse 1,0,0
    int            vphase = 0;
    bit            pend_deq = 1'b0;
    bit            rnd_ready = 1'b0;

    always @(posedge clk) begin
        bit en;
        #1;
        if (pend_deq && ram_q.size() > 0) void'(ram_q.pop_front());
        pend_deq = 1'b0;
        vphase++;
        case (vmode)
            0:       en = 1'b1;
            1:       en = ($urandom_range(0, 1) == 1);
            default: en = (vphase % 3 == 0);
        endcase
        if (ram_q.size() > 0 && en) begin
            ram_read_valid = 1'b1;
            ram_read_data  = ram_q[0];
        end else begin
            ram_read_valid = 1'b0;
            ram_read_data  = DW'($urandom);
        end
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- behavioural model + monitor ---------------------------
    int            m_phase = 0;  // 0 idle, 1 request, 2 fetching, 3 draining, 4 done
    bit            m_alive = 1'b0;
    logic [31:0]   m_addr = '0, m_size = '0, m_left = '0;
    logic [DW:0]   m_fifo[$];
    logic [DW:0]   exp_stream[$];

    int n_req, n_deq, n_done, n_pop, n_outv, n_bad_deq, n_acc;
    int done_cyc, acc_cyc, first_pop_cyc, lastpop_cyc;
    logic [31:0]   req_addr, req_size;
    logic [DW-1:0] pop_log[$];
    bit            last_log[$];

    logic e_ready, e_req, e_deq, e_valid, e_last, e_busy, e_done, was_last;
    logic [DW-1:0] e_data;
    logic [DW:0]   sb;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk("reset_ctl", 32'({cmd_ready, ram_read_req, ram_read_dequeue, out_valid,
                                  out_last, busy, done}), 32'd0);
            chk("reset_addr", ram_read_addr, 32'd0);
            chk("reset_size", ram_read_size, 32'd0);
            chk("reset_data", 32'(out_data), 32'd0);
            m_phase = 0; m_alive = 1'b0;
            m_addr = '0; m_size = '0; m_left = '0;
            m_fifo.delete();
            exp_stream.delete();
        end else begin
            e_ready = m_alive && (m_phase == 0);
            e_req   = (m_phase == 1);
            e_deq   = (m_phase == 2) && ram_read_valid && (m_fifo.size() < DEPTH) && (m_left != 0);
            e_valid = (m_fifo.size() != 0);
            e_data  = e_valid ? m_fifo[0][DW-1:0] : '0;
            e_last  = e_valid && m_fifo[0][DW];
            e_busy  = (m_phase != 0);
            e_done  = (m_phase == 4);
            chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
            chk("ram_read_req", 32'(ram_read_req), 32'(e_req));
            chk("ram_read_addr", ram_read_addr, m_addr);
            chk("ram_read_size", ram_read_size, m_size);
            chk("ram_read_dequeue", 32'(ram_read_dequeue), 32'(e_deq));
            chk("out_valid", 32'(out_valid), 32'(e_valid));
            chk("out_data", 32'(out_data), 32'(e_data));
            chk("out_last", 32'(out_last), 32'(e_last));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));

            // monitor
            if (ram_read_req) begin n_req++; req_addr = ram_read_addr; req_size = ram_read_size; end
            if (ram_read_dequeue) n_deq++;
            if (ram_read_dequeue && !ram_read_valid) n_bad_deq++;
            if (out_valid) n_outv++;
            if (done) begin n_done++; done_cyc = cyc; end
            if (cmd_valid && cmd_ready) begin n_acc++; acc_cyc = cyc; end
            pend_deq = ram_read_dequeue;

            // scoreboard: stream order against what was loaded into the RAM
            if (out_valid && out_ready) begin
                if (n_pop == 0) first_pop_cyc = cyc;
                n_pop++;
                if (out_last) lastpop_cyc = cyc;
                pop_log.push_back(out_data);
                last_log.push_back(out_last);
                if (exp_stream.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL stream_extra: got 0x%0h, expected no word (cycle %0d)", out_data, cyc);
                end else begin
                    sb = exp_stream.pop_front();
                    chk("stream_data", 32'(out_data), 32'(sb[DW-1:0]));
                    chk("stream_last", 32'(out_last), 32'(sb[DW]));
                end
            end

            // advance the model across the coming edge
            was_last = (m_left == 32'd1);
            if (e_valid && out_ready) void'(m_fifo.pop_front());
            if (e_deq) begin
                m_fifo.push_back({was_last, ram_read_data});
                m_left = m_left - 32'd1;
            end
            case (m_phase)
                0: if (e_ready && cmd_valid) begin
                       m_addr = cmd_addr; m_size = cmd_size; m_left = cmd_size;
                       m_phase = (cmd_size == 0) ? 4 : 1;
                   end
                1: m_phase = 2;
                2: if (e_deq && was_last) m_phase = 3;
                3: if (e_valid && out_ready && e_last) m_phase = 4;
                default: m_phase = 0;
            endcase
            m_alive = 1'b1;
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic clr();
        n_req = 0; n_deq = 0; n_done = 0; n_pop = 0; n_outv = 0; n_bad_deq = 0; n_acc = 0;
        done_cyc = 0; acc_cyc = 0; first_pop_cyc = 0; lastpop_cyc = 0;
        req_addr = '0; req_size = '0;
        pop_log.delete(); last_log.delete();
    endtask

    task automatic load(input int n, input bit rnd, input logic [DW-1:0] base);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd ? DW'($urandom) : base + DW'(i);
            ram_q.push_back(w);
            exp_stream.push_back({(i == n - 1), w});
        end
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] size);
        int k;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = addr; cmd_size = size;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        if (k == 500) timeout_fail("accept");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, input string name);
        int k;
        for (k = 0; k < max; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == max) timeout_fail(name);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3;
        rst = 1'b0;
        ram_q.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- test sequence -----------------------------------------
    initial begin
        int k;
        clr();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk); #1;
        chk("ready_before_edge", 32'(cmd_ready), 32'd0);
        @(negedge clk); #1;
        chk("ready_after_edge", 32'(cmd_ready), 32'd1);

        // basic: 0xA1..0xA4, consumer always ready
        vmode = 0; out_ready = 1'b1;
        load(4, 1'b0, 8'hA1);
        clr();
        issue(32'h10, 32'd4);
        wait_done(100, "basic_done");
        chk("basic_nreq", 32'(n_req), 32'd1);
        chk("basic_req_addr", req_addr, 32'h10);
        chk("basic_req_size", req_size, 32'd4);
        chk("basic_npop", 32'(n_pop), 32'd4);
        if (pop_log.size() == 4) begin
            chk("basic_w0", 32'(pop_log[0]), 32'hA1);
            chk("basic_w1", 32'(pop_log[1]), 32'hA2);
            chk("basic_w2", 32'(pop_log[2]), 32'hA3);
            chk("basic_w3", 32'(pop_log[3]), 32'hA4);
            chk("basic_lasts", 32'({last_log[3], last_log[2], last_log[1], last_log[0]}), 32'b1000);
        end
        // handshake cycle N: REQ N+1, dequeue N+2, first word out N+3
        chk("basic_first_lat", 32'(first_pop_cyc - acc_cyc), 32'd3);
        chk("basic_done_lat", 32'(done_cyc - lastpop_cyc), 32'd1);
        @(negedge clk); #1;
        chk("basic_busy_after", 32'(busy), 32'd0);

        // backpressure: size 8, consumer stalled for 10 cycles
        out_ready = 1'b0;
        load(8, 1'b0, 8'h30);
        clr();
        issue(32'h200, 32'd8);
        repeat (10) @(negedge clk);
        #1;
        chk("bp_ndeq", 32'(n_deq), 32'd4);
        chk("bp_deq_full", 32'(ram_read_dequeue), 32'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done(100, "bp_done");
        chk("bp_npop", 32'(n_pop), 32'd8);
        for (int i = 0; i < 8 && i < pop_log.size(); i++)
            chk("bp_word", 32'(pop_log[i]), 32'h30 + 32'(i));

        // sparse RAM valid, size 3
        vmode = 2;
        load(3, 1'b0, 8'h50);
        clr();
        issue(32'h300, 32'd3);
        wait_done(200, "sparse_done");
        chk("sparse_ndeq", 32'(n_deq), 32'd3);
        chk("sparse_bad_deq", 32'(n_bad_deq), 32'd0);
        if (pop_log.size() == 3) begin
            chk("sparse_words", 32'({pop_log[0], pop_log[1], pop_log[2]}), 32'h505152);
            chk("sparse_lasts", 32'({last_log[2], last_log[1], last_log[0]}), 32'b100);
        end else chk("sparse_npop", 32'(pop_log.size()), 32'd3);

        // zero size: no request, no data, done in the cycle after the handshake cycle
        vmode = 0;
        clr();
        issue(32'h400, 32'd0);
        wait_done(20, "zero_done");
        chk("zero_nreq", 32'(n_req), 32'd0);
        chk("zero_noutv", 32'(n_outv), 32'd0);
        chk("zero_done_lat", 32'(done_cyc - acc_cyc), 32'd1);

        // maximum size: streams without a last marker, then abandoned by reset
        for (int i = 0; i < 5; i++) begin
            ram_q.push_back(8'hC0 + 8'(i));
            exp_stream.push_back({1'b0, 8'hC0 + 8'(i)});
        end
        clr();
        issue(32'h700, 32'hFFFF_FFFF);
        repeat (12) @(negedge clk);
        #1;
        chk("max_req_size", req_size, 32'hFFFF_FFFF);
        chk("max_npop", 32'(n_pop), 32'd5);
        chk("max_busy", 32'(busy), 32'd1);
        pulse_reset();

        // reset mid-stream after two of six words
        load(6, 1'b0, 8'h70);
        clr();
        issue(32'h500, 32'd6);
        for (k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (n_pop >= 2) break;
        end
        if (k == 50) timeout_fail("rstmid_two_words");
        @(posedge clk); #3;
        rst = 1'b0;
        ram_q.delete();
        #1;
        chk("rstmid_ctl", 32'({cmd_ready, ram_read_req, ram_read_dequeue, out_valid,
                               out_last, busy, done}), 32'd0);
        chk("rstmid_addr", ram_read_addr, 32'd0);
        chk("rstmid_data", 32'(out_data), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        chk("rstmid_ready", 32'(cmd_ready), 32'd1);
        load(2, 1'b0, 8'h90);
        clr();
        issue(32'h600, 32'd2);
        wait_done(100, "rstmid_new_done");
        chk("rstmid_npop", 32'(n_pop), 32'd2);
        if (pop_log.size() == 2)
            chk("rstmid_words", 32'({pop_log[0], pop_log[1]}), 32'h9091);

        // back-to-back with cmd_valid held
        load(3, 1'b0, 8'hD0);
        load(2, 1'b0, 8'hE0);
        clr();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = 32'h800; cmd_size = 32'd3;
        for (k = 0; k < 50; k++) begin @(negedge clk); if (cmd_ready) break; end
        if (k == 50) timeout_fail("b2b_first_accept");
        @(posedge clk); #1;
        cmd_addr = 32'h900; cmd_size = 32'd2;
        for (k = 0; k < 100; k++) begin @(negedge clk); if (cmd_ready) break; end
        if (k == 100) timeout_fail("b2b_second_accept");
        #1;
        chk("b2b_gap", 32'(acc_cyc - done_cyc), 32'd1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk); #1;
        chk("b2b_req", 32'(ram_read_req), 32'd1);
        chk("b2b_addr", ram_read_addr, 32'h900);
        chk("b2b_size", ram_read_size, 32'd2);
        wait_done(100, "b2b_done");
        chk("b2b_npop", 32'(n_pop), 32'd5);
        chk("b2b_nreq", 32'(n_req), 32'd2);

        // randomized commands, RAM validity and consumer readiness
        rnd_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            int n;
            vmode = $urandom_range(0, 2);
            n = $urandom_range(0, 10);
            load(n, 1'b1, 8'h00);
            issue(32'($urandom), 32'(n));
            wait_done(2000, "rand_done");
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rand_stream_left", 32'(exp_stream.size()), 32'd0);
        chk("rand_ram_left", 32'(ram_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule
